// File: rtl/dti_pack.sv
// Shared GNPD flit definitions for the DTI-to-GNPD bridge.
package dti_pack;

  localparam int GNPD_FLIT_DW   = 80;
  localparam int GNPD_FLIT_KW   = 10;
  localparam int GNPD_PAYLOAD_W = GNPD_FLIT_KW + GNPD_FLIT_DW;
  localparam int GNPD_NODE_W    = 6;

  typedef struct packed {
    logic [GNPD_FLIT_KW-1:0] keep;
    logic [GNPD_FLIT_DW-1:0] data;
  } gnpd_flit_t;

  // Width of an index into n slots, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dti_gnpd_ser.sv
// Request serialiser: splits one AXIS beat into NF GNPD flits, trimming
// trailing all-zero-keep flits from the last beat of a packet.
module dti_gnpd_ser
  import dti_pack::*;
#(
  parameter int                     AXIS_DW  = 160,
  parameter int                     TID_W    = 3,
  parameter logic [GNPD_NODE_W-1:0] TGT_BASE = 6'd8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_ok,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [AXIS_DW-1:0]     s_data,
  input  logic [AXIS_DW/8-1:0]   s_keep,
  input  logic                   s_last,
  input  logic [TID_W-1:0]       s_tid,
  output logic                   m_valid,
  input  logic                   m_ready,
  output gnpd_flit_t             m_flit,
  output logic                   m_last,
  output logic [GNPD_NODE_W-1:0] m_tgtid,
  output logic                   ser_idle
);

  localparam int NF   = AXIS_DW / GNPD_FLIT_DW;
  localparam int KW   = AXIS_DW / 8;
  localparam int FI_W = idx_w(NF);

  logic                   beat_valid_q, beat_valid_d;
  logic [AXIS_DW-1:0]     data_q, data_d;
  logic [KW-1:0]          keep_q, keep_d;
  logic                   last_q, last_d;
  logic [FI_W-1:0]        fi_q, fi_d;
  logic [FI_W-1:0]        last_fi_q, last_fi_d;
  logic                   in_pkt_q, in_pkt_d;
  logic [GNPD_NODE_W-1:0] tgtid_q, tgtid_d;

  logic fire, final_flit, accept;

  // Index of the flit that closes this beat.
  function automatic logic [FI_W-1:0] final_idx(input logic [KW-1:0] keep,
                                                 input logic          last);
    final_idx = FI_W'(NF - 1);
    if (last) begin
      final_idx = '0;
      for (int i = 1; i < NF; i++)
        if (|keep[GNPD_FLIT_KW*i +: GNPD_FLIT_KW]) final_idx = FI_W'(i);
    end
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    beat_valid_d = beat_valid_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    fi_d         = fi_q;
    last_fi_d    = last_fi_q;
    in_pkt_d     = in_pkt_q;
    tgtid_d      = tgtid_q;

    fire       = beat_valid_q && m_ready;
    final_flit = (fi_q == last_fi_q);
    s_ready    = (!beat_valid_q || (fire && final_flit)) && (in_pkt_q || start_ok);
    accept     = s_valid && s_ready;

    if (fire) begin
      if (final_flit) beat_valid_d = 1'b0;
      else            fi_d         = fi_q + 1'b1;
    end

    if (accept) begin
      beat_valid_d = 1'b1;
      data_d       = s_data;
      keep_d       = s_keep;
      last_d       = s_last;
      fi_d         = '0;
      last_fi_d    = final_idx(s_keep, s_last);
      in_pkt_d     = !s_last;
      if (!in_pkt_q) tgtid_d = TGT_BASE + GNPD_NODE_W'(s_tid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too so data outputs read 0 out of reset.
      beat_valid_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      fi_q         <= '0;
      last_fi_q    <= '0;
      in_pkt_q     <= 1'b0;
      tgtid_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      beat_valid_q <= beat_valid_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      fi_q         <= fi_d;
      last_fi_q    <= last_fi_d;
      in_pkt_q     <= in_pkt_d;
      tgtid_q      <= tgtid_d;
    end
  end

  assign m_valid     = beat_valid_q;
  assign m_flit.data = data_q[GNPD_FLIT_DW*fi_q +: GNPD_FLIT_DW];
  assign m_flit.keep = keep_q[GNPD_FLIT_KW*fi_q +: GNPD_FLIT_KW];
  assign m_last      = beat_valid_q && last_q && final_flit;
  assign m_tgtid     = tgtid_q;
  assign ser_idle    = !beat_valid_q && !in_pkt_q;

endmodule

// File: rtl/dti_gnpd_bridge.sv
// DTI AXI-Stream <-> GNPD flit bridge: serialised request path plus an
// inline response deserialiser that gathers flits back into AXIS beats.
module dti_gnpd_bridge
  import dti_pack::*;
#(
  parameter int                     AXIS_DW  = 160,
  parameter int                     TBU_NUM  = 8,
  parameter int                     TID_W    = $clog2(TBU_NUM),
  parameter logic [GNPD_NODE_W-1:0] SRC_ID   = 6'd0,
  parameter logic [GNPD_NODE_W-1:0] TGT_BASE = 6'd8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      partial_reset,
  output logic                      idle,
  input  logic                      req_tvalid,
  output logic                      req_tready,
  input  logic [AXIS_DW-1:0]        req_tdata,
  input  logic [AXIS_DW/8-1:0]      req_tkeep,
  input  logic                      req_tlast,
  input  logic [TID_W-1:0]          req_tid,
  output logic                      rsp_tvalid,
  input  logic                      rsp_tready,
  output logic [AXIS_DW-1:0]        rsp_tdata,
  output logic [AXIS_DW/8-1:0]      rsp_tkeep,
  output logic                      rsp_tlast,
  output logic [TID_W-1:0]          rsp_tid,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [GNPD_PAYLOAD_W-1:0] req_payload,
  output logic [GNPD_NODE_W-1:0]    req_srcid,
  output logic [GNPD_NODE_W-1:0]    req_tgtid,
  output logic                      req_qos,
  output logic                      req_last,
  input  logic                      req_threshold,
  input  logic                      rsp_valid,
  output logic                      rsp_ready,
  input  logic [GNPD_PAYLOAD_W-1:0] rsp_payload,
  input  logic [GNPD_NODE_W-1:0]    rsp_srcid,
  input  logic [GNPD_NODE_W-1:0]    rsp_tgtid,
  input  logic                      rsp_qos,
  input  logic                      rsp_last,
  output logic                      rsp_threshold
);

  localparam int NF   = AXIS_DW / GNPD_FLIT_DW;
  localparam int KW   = AXIS_DW / 8;
  localparam int FI_W = idx_w(NF);

  // ---------------- request path ----------------
  gnpd_flit_t req_flit;
  logic       ser_idle;

  dti_gnpd_ser #(
    .AXIS_DW  (AXIS_DW),
    .TID_W    (TID_W),
    .TGT_BASE (TGT_BASE)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .start_ok (req_threshold && !partial_reset),
    .s_valid  (req_tvalid),
    .s_ready  (req_tready),
    .s_data   (req_tdata),
    .s_keep   (req_tkeep),
    .s_last   (req_tlast),
    .s_tid    (req_tid),
    .m_valid  (req_valid),
    .m_ready  (req_ready),
    .m_flit   (req_flit),
    .m_last   (req_last),
    .m_tgtid  (req_tgtid),
    .ser_idle (ser_idle)
  );

  assign req_payload = req_flit;
  assign req_srcid   = SRC_ID;
  assign req_qos     = 1'b1;

  // ---------------- response path ----------------
  gnpd_flit_t             rsp_flit;
  logic [GNPD_NODE_W-1:0] tid_diff;
  logic                   rsp_fire, rsp_done;

  logic [FI_W-1:0]    ri_q, ri_d;
  logic [AXIS_DW-1:0] acc_data_q, acc_data_d;
  logic [KW-1:0]      acc_keep_q, acc_keep_d;
  logic               tvalid_q, tvalid_d;
  logic [AXIS_DW-1:0] tdata_q, tdata_d;
  logic [KW-1:0]      tkeep_q, tkeep_d;
  logic               tlast_q, tlast_d;
  logic [TID_W-1:0]   tid_q, tid_d;

  assign rsp_flit = rsp_payload;
  assign tid_diff = rsp_srcid - TGT_BASE;

  always_comb begin
    ri_d       = ri_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tid_d      = tid_q;

    rsp_ready = !tvalid_q || rsp_tready;
    rsp_fire  = rsp_valid && rsp_ready;
    rsp_done  = rsp_fire && (rsp_last || (ri_q == FI_W'(NF - 1)));

    if (tvalid_q && rsp_tready) tvalid_d = 1'b0;

    if (rsp_fire) begin
      acc_data_d[GNPD_FLIT_DW*ri_q +: GNPD_FLIT_DW] = rsp_flit.data;
      acc_keep_d[GNPD_FLIT_KW*ri_q +: GNPD_FLIT_KW] = rsp_flit.keep;
      ri_d = ri_q + 1'b1;
    end

    // The accumulator is cleared on hand-off, so slots skipped by an early last stay 0.
    if (rsp_done) begin
      tvalid_d   = 1'b1;
      tdata_d    = acc_data_d;
      tkeep_d    = acc_keep_d;
      tlast_d    = rsp_last;
      tid_d      = tid_diff[TID_W-1:0];
      acc_data_d = '0;
      acc_keep_d = '0;
      ri_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ri_q       <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tid_q      <= '0;
    end else begin
      ri_q       <= ri_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tid_q      <= tid_d;
    end
  end

  assign rsp_tvalid    = tvalid_q;
  assign rsp_tdata     = tdata_q;
  assign rsp_tkeep     = tkeep_q;
  assign rsp_tlast     = tlast_q;
  assign rsp_tid       = tid_q;
  assign rsp_threshold = !tvalid_q;

  assign idle = ser_idle && (ri_q == '0) && !tvalid_q;

  logic unused_ok;
  assign unused_ok = ^{rsp_qos, rsp_tgtid, tid_diff};

endmodule

// File: tb/tb_dti_gnpd_bridge.sv
// Directed self-checking bench for dti_gnpd_bridge at AXIS_DW=160 (NF=2).
module tb_dti_gnpd_bridge;

  logic         clk = 1'b0;
  logic         rst, partial_reset, idle;
  logic         req_tvalid, req_tready, req_tlast;
  logic [159:0] req_tdata;
  logic [19:0]  req_tkeep;
  logic [2:0]   req_tid;
  logic         rsp_tvalid, rsp_tready, rsp_tlast;
  logic [159:0] rsp_tdata;
  logic [19:0]  rsp_tkeep;
  logic [2:0]   rsp_tid;
  logic         req_valid, req_ready, req_qos, req_last, req_threshold;
  logic [89:0]  req_payload;
  logic [5:0]   req_srcid, req_tgtid;
  logic         rsp_valid, rsp_ready, rsp_qos, rsp_last, rsp_threshold;
  logic [89:0]  rsp_payload;
  logic [5:0]   rsp_srcid, rsp_tgtid;

  int tests = 0;
  int fails = 0;

  logic [79:0] l1 = 80'h1111_2222_3333_4444_5555;
  logic [79:0] h1 = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
  logic [79:0] l2 = 80'h0123_4567_89AB_CDEF_0F0F;
  logic [79:0] h2 = 80'hFEDC_BA98_7654_3210_F0F0;
  logic [79:0] r0 = 80'h5A5A_5A5A_5A5A_5A5A_5A5A;
  logic [79:0] r1 = 80'hC3C3_C3C3_C3C3_C3C3_C3C3;
  logic [79:0] r2 = 80'h0000_1111_0000_2222_0000;
  logic [79:0] r3 = 80'h9999_8888_7777_6666_5555;

  always #5 clk = ~clk;

  dti_gnpd_bridge #(
    .AXIS_DW  (160),
    .TBU_NUM  (8),
    .SRC_ID   (6'd0),
    .TGT_BASE (6'd8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .partial_reset (partial_reset),
    .idle          (idle),
    .req_tvalid    (req_tvalid),
    .req_tready    (req_tready),
    .req_tdata     (req_tdata),
    .req_tkeep     (req_tkeep),
    .req_tlast     (req_tlast),
    .req_tid       (req_tid),
    .rsp_tvalid    (rsp_tvalid),
    .rsp_tready    (rsp_tready),
    .rsp_tdata     (rsp_tdata),
    .rsp_tkeep     (rsp_tkeep),
    .rsp_tlast     (rsp_tlast),
    .rsp_tid       (rsp_tid),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_payload   (req_payload),
    .req_srcid     (req_srcid),
    .req_tgtid     (req_tgtid),
    .req_qos       (req_qos),
    .req_last      (req_last),
    .req_threshold (req_threshold),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_payload   (rsp_payload),
    .rsp_srcid     (rsp_srcid),
    .rsp_tgtid     (rsp_tgtid),
    .rsp_qos       (rsp_qos),
    .rsp_last      (rsp_last),
    .rsp_threshold (rsp_threshold)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [159:0] d, input logic [19:0] k,
                            input logic l, input logic [2:0] t);
    req_tvalid = 1'b1;
    req_tdata  = d;
    req_tkeep  = k;
    req_tlast  = l;
    req_tid    = t;
  endtask

  task automatic drive_flit(input logic [89:0] p, input logic [5:0] src, input logic l);
    rsp_valid   = 1'b1;
    rsp_payload = p;
    rsp_srcid   = src;
    rsp_last    = l;
  endtask

  initial begin
    int  nflits, nlast, bidx;
    logic acc, fl, lst;

    rst = 1'b1; partial_reset = 1'b0;
    req_tvalid = 1'b0; req_tdata = '0; req_tkeep = '0; req_tlast = 1'b0; req_tid = '0;
    rsp_tready = 1'b1; req_ready = 1'b1; req_threshold = 1'b1;
    rsp_valid = 1'b0; rsp_payload = '0; rsp_srcid = '0; rsp_tgtid = 6'd0;
    rsp_qos = 1'b0; rsp_last = 1'b0;
    tick(); tick();

    // reset state
    check("rst_req_valid", req_valid, 0);
    check("rst_req_last", req_last, 0);
    check("rst_rsp_tvalid", rsp_tvalid, 0);
    check("rst_idle", idle, 1);
    check("rst_rsp_threshold", rsp_threshold, 1);
    check("rst_req_qos", req_qos, 1);
    check("rst_req_payload", req_payload, 0);
    check("rst_rsp_tdata", rsp_tdata, 0);
    rst = 1'b0;

    // full-keep single-beat packet, tid 3, with a stalled flit
    drive_beat({h1, l1}, 20'hFFFFF, 1'b1, 3'd3);
    #1 check("t1_tready", req_tready, 1);
    tick();
    req_tvalid = 1'b0; req_ready = 1'b0;
    #1;
    check("t1_f0_valid", req_valid, 1);
    check("t1_f0_payload", req_payload, {10'h3FF, l1});
    check("t1_tgtid", req_tgtid, 6'd11);
    check("t1_srcid", req_srcid, 6'd0);
    check("t1_f0_last", req_last, 0);
    check("t1_idle_busy", idle, 0);
    tick();
    check("t1_stall_payload", req_payload, {10'h3FF, l1});
    check("t1_stall_last", req_last, 0);
    req_ready = 1'b1;
    tick();
    check("t1_f1_payload", req_payload, {10'h3FF, h1});
    check("t1_f1_last", req_last, 1);
    tick();
    check("t1_done_valid", req_valid, 0);
    check("t1_done_idle", idle, 1);

    // low-half keep only: single flit closes the packet
    drive_beat({h2, l2}, 20'h003FF, 1'b1, 3'd0);
    tick();
    req_tvalid = 1'b0;
    #1;
    check("t2_last", req_last, 1);
    check("t2_payload", req_payload, {10'h3FF, l2});
    check("t2_tgtid", req_tgtid, 6'd8);
    tick();
    check("t2_done_valid", req_valid, 0);

    // all-zero keep last beat still sends flit 0 with last
    drive_beat({h2, l2}, 20'h00000, 1'b1, 3'd1);
    tick();
    req_tvalid = 1'b0;
    #1;
    check("t2z_valid", req_valid, 1);
    check("t2z_last", req_last, 1);
    check("t2z_payload", req_payload, {10'h000, l2});
    tick();
    check("t2z_done_valid", req_valid, 0);

    // threshold gates packet start only
    req_threshold = 1'b0;
    drive_beat({h1, l1}, 20'hFFFFF, 1'b0, 3'd5);
    #1 check("t3_blocked_tready", req_tready, 0);
    tick();
    check("t3_blocked_valid", req_valid, 0);
    req_threshold = 1'b1;
    #1 check("t3_open_tready", req_tready, 1);
    tick();
    req_threshold = 1'b0;
    drive_beat({h2, l2}, 20'hFFFFF, 1'b1, 3'd0);
    #1;
    check("t3_a0_tready", req_tready, 0);
    check("t3_a0_tgtid", req_tgtid, 6'd13);
    check("t3_a0_last", req_last, 0);
    tick();
    check("t3_a1_payload", req_payload, {10'h3FF, h1});
    check("t3_a1_last", req_last, 0);
    check("t3_mid_tready", req_tready, 1);
    tick();
    req_tvalid = 1'b0;
    #1;
    check("t3_b0_payload", req_payload, {10'h3FF, l2});
    check("t3_b0_tgtid", req_tgtid, 6'd13);
    tick();
    check("t3_b1_payload", req_payload, {10'h3FF, h2});
    check("t3_b1_last", req_last, 1);
    tick();
    check("t3_idle", idle, 1);
    req_threshold = 1'b1;

    // response: two flits, second with last, srcid 9 -> tid 1
    rsp_tready = 1'b0;
    drive_flit({10'h3FF, r0}, 6'd9, 1'b0);
    #1 check("t4_rsp_ready", rsp_ready, 1);
    tick();
    check("t4_mid_tvalid", rsp_tvalid, 0);
    check("t4_mid_idle", idle, 0);
    drive_flit({10'h3FF, r1}, 6'd9, 1'b1);
    tick();
    rsp_valid = 1'b0;
    #1;
    check("t4_tvalid", rsp_tvalid, 1);
    check("t4_tdata", rsp_tdata, {r1, r0});
    check("t4_tkeep", rsp_tkeep, 20'hFFFFF);
    check("t4_tlast", rsp_tlast, 1);
    check("t4_tid", rsp_tid, 3'd1);
    check("t4_threshold", rsp_threshold, 0);
    check("t4_rsp_ready_full", rsp_ready, 0);
    tick();
    check("t4_hold_tvalid", rsp_tvalid, 1);
    rsp_tready = 1'b1;
    tick();
    check("t4_drained_tvalid", rsp_tvalid, 0);
    check("t4_drained_idle", idle, 1);

    // single-flit last response leaves upper slice zero
    rsp_tready = 1'b0;
    drive_flit({10'h2AA, r2}, 6'd12, 1'b1);
    tick();
    rsp_valid = 1'b0;
    #1;
    check("t5_tdata", rsp_tdata, {80'h0, r2});
    check("t5_tkeep", rsp_tkeep, {10'h000, 10'h2AA});
    check("t5_tid", rsp_tid, 3'd4);

    // consume and refill in the same cycle
    rsp_tready = 1'b1;
    drive_flit({10'h155, r3}, 6'd8, 1'b1);
    #1 check("t5_replace_ready", rsp_ready, 1);
    tick();
    rsp_valid = 1'b0;
    #1;
    check("t5_replace_tvalid", rsp_tvalid, 1);
    check("t5_replace_tdata", rsp_tdata, {80'h0, r3});
    check("t5_replace_tid", rsp_tid, 3'd0);
    tick();
    check("t5_replace_drain", rsp_tvalid, 0);

    // two flits without last -> full beat, tlast 0
    drive_flit({10'h3FF, r0}, 6'd15, 1'b0);
    tick();
    drive_flit({10'h001, r1}, 6'd15, 1'b0);
    tick();
    rsp_valid = 1'b0;
    #1;
    check("t6_tvalid", rsp_tvalid, 1);
    check("t6_tlast", rsp_tlast, 0);
    check("t6_tkeep", rsp_tkeep, {10'h001, 10'h3FF});
    check("t6_tid", rsp_tid, 3'd7);
    tick();

    // partial reset during a 3-beat packet
    nflits = 0; nlast = 0; bidx = 0;
    drive_beat({h1, l1}, 20'hFFFFF, 1'b0, 3'd2);
    for (int c = 0; c < 40 && nlast == 0; c++) begin
      #1;
      acc = req_tvalid && req_tready;
      fl  = req_valid && req_ready;
      lst = req_last;
      @(posedge clk);
      #1;
      if (fl) begin
        nflits++;
        if (lst) nlast++;
      end
      if (acc) begin
        bidx++;
        req_tlast = (bidx >= 2);
      end
      if (bidx >= 1) partial_reset = 1'b1;
    end
    check("t7_flits", nflits, 6);
    check("t7_last_seen", nlast, 1);
    check("t7_beats", bidx, 3);
    check("t7_idle", idle, 1);
    #1 check("t7_held_tready", req_tready, 0);
    partial_reset = 1'b0;
    #1 check("t7_release_tready", req_tready, 1);
    tick();
    req_tvalid = 1'b0;
    tick(); tick();
    check("t7_final_idle", idle, 1);

    // rst mid-packet aborts it; next packet starts at flit 0
    req_ready = 1'b0;
    drive_beat({h1, l1}, 20'hFFFFF, 1'b0, 3'd2);
    tick();
    req_tvalid = 1'b0;
    #1 check("t8_inflight_valid", req_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t8_rst_valid", req_valid, 0);
    check("t8_rst_idle", idle, 1);
    req_ready = 1'b1;
    drive_beat({h2, l2}, 20'hFFFFF, 1'b1, 3'd6);
    #1 check("t8_new_tready", req_tready, 1);
    tick();
    req_tvalid = 1'b0;
    #1;
    check("t8_new_payload", req_payload, {10'h3FF, l2});
    check("t8_new_tgtid", req_tgtid, 6'd14);
    check("t8_new_last", req_last, 0);
    tick();
    check("t8_new_f1_last", req_last, 1);
    tick();
    check("t8_end_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
